// File: rtl/unidade_controle_jogo.sv
// unidade_controle_jogo -- Moore control unit for the memory-compare game.
// Sequences the address counter, switch register and comparator: waits for
// iniciar, captures one player move per stored entry (rising edge of jogada),
// checks the comparator and advances the counter until success or error.
// Optional feature: define UC_JOGO_TIMEOUT_EN to build the inactivity timeout
// counter and the fim_timeout end state (TIMEOUT_CYCLES cycles in espera).
module unidade_controle_jogo #(
   parameter int TIMEOUT_CYCLES = 5000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       iniciar,
   input  logic       jogada,
   input  logic       igual,
   input  logic       fim_contagem,
   output logic       zeraC,
   output logic       contaC,
   output logic       zeraR,
   output logic       registraR,
   output logic       pronto,
   output logic       acertou,
   output logic       errou,
   output logic       timeout,
   output logic [3:0] db_estado
);

   // State codes double as the debug display value.
   typedef enum logic [3:0] {
      INICIAL     = 4'h0,
      PREPARACAO  = 4'h1,
      ESPERA      = 4'h2,
      REGISTRA    = 4'h4,
      COMPARACAO  = 4'h5,
      PROXIMO     = 4'h6,
      FIM_ACERTO  = 4'hA,
      FIM_TIMEOUT = 4'hD,
      FIM_ERRO    = 4'hE
   } estado_t;

   estado_t estado_q, estado_d;
   logic    jogada_ant_q, jogada_ant_d;
   logic    jogada_borda;

   // Previous sample of jogada, used to turn the level into a single move pulse.
   always_comb begin
      jogada_ant_d = jogada;
   end

   // A move is only the 0->1 transition; holding the switch does not retrigger.
   assign jogada_borda = jogada & ~jogada_ant_q;

`ifdef UC_JOGO_TIMEOUT_EN
   localparam int CONT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CONT_W-1:0] CONT_LIMITE = CONT_W'(TIMEOUT_CYCLES - 1);

   logic [CONT_W-1:0] cont_q, cont_d;
   logic              expirou;

   // Inactivity counter: runs only while waiting for a move, cleared elsewhere.
   // The state leaves espera at the limit, so the counter never wraps.
   always_comb begin
      cont_d = '0;
      if (estado_q == ESPERA) begin
         cont_d = cont_q + 1'b1;
      end
   end

   assign expirou = (cont_q == CONT_LIMITE);

   // Timeout counter register.
   always_ff @(posedge clock) begin
      if (reset) begin
         cont_q <= '0;
      end else begin
         cont_q <= cont_d;
      end
   end
`endif

   // State and edge-detect registers; reset is synchronous and wins over all inputs.
   always_ff @(posedge clock) begin
      // NOTE: non-blocking assignments here so every flop samples pre-edge values.
      if (reset) begin
         estado_q     <= INICIAL;
         jogada_ant_q <= 1'b0;
      end else begin
         estado_q     <= estado_d;
         jogada_ant_q <= jogada_ant_d;
      end
   end

   // Next-state logic; iniciar is only honoured in inicial and the end states.
   always_comb begin
      // NOTE: default first so no path through the case leaves estado_d unassigned (no latch).
      estado_d = estado_q;
      case (estado_q)
         INICIAL: begin
            if (iniciar) estado_d = PREPARACAO;
         end
         PREPARACAO: begin
            estado_d = ESPERA;
         end
         ESPERA: begin
            // A move edge takes priority over a timeout expiring in the same cycle.
            if (jogada_borda) begin
               estado_d = REGISTRA;
            end
`ifdef UC_JOGO_TIMEOUT_EN
            else if (expirou) begin
               estado_d = FIM_TIMEOUT;
            end
`endif
         end
         REGISTRA: begin
            estado_d = COMPARACAO;
         end
         COMPARACAO: begin
            if (!igual) begin
               estado_d = FIM_ERRO;
            end else if (fim_contagem) begin
               estado_d = FIM_ACERTO;
            end else begin
               estado_d = PROXIMO;
            end
         end
         PROXIMO: begin
            estado_d = ESPERA;
         end
         FIM_ACERTO, FIM_ERRO: begin
            if (iniciar) estado_d = PREPARACAO;
         end
`ifdef UC_JOGO_TIMEOUT_EN
         FIM_TIMEOUT: begin
            if (iniciar) estado_d = PREPARACAO;
         end
`endif
         // Any code not listed above (including fim_timeout when the feature is
         // not built) recovers to inicial.
         default: begin
            estado_d = INICIAL;
         end
      endcase
   end

   // Moore output decode: every output depends on the state register alone.
   always_comb begin
      zeraC     = 1'b0;
      contaC    = 1'b0;
      zeraR     = 1'b0;
      registraR = 1'b0;
      pronto    = 1'b0;
      acertou   = 1'b0;
      errou     = 1'b0;
      timeout   = 1'b0;
      case (estado_q)
         PREPARACAO: begin
            zeraC = 1'b1;
            zeraR = 1'b1;
         end
         REGISTRA: begin
            registraR = 1'b1;
         end
         PROXIMO: begin
            contaC = 1'b1;
         end
         FIM_ACERTO: begin
            pronto  = 1'b1;
            acertou = 1'b1;
         end
         FIM_ERRO: begin
            pronto = 1'b1;
            errou  = 1'b1;
         end
`ifdef UC_JOGO_TIMEOUT_EN
         FIM_TIMEOUT: begin
            pronto  = 1'b1;
            timeout = 1'b1;
         end
`endif
         default: begin
         end
      endcase
   end

   assign db_estado = estado_q;

endmodule
